alu_iter: RTL and testbench
===========================

// Module: alu_iter
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle execute ALU. Registers every result
//  and adds iterative multiply/divide (MUL, MULHU, DIVU, REMU, DIV, REM) on a shift-add / restoring
//  datapath. Sits in the execute stage between operand fetch and writeback. One op in flight.
// PARAMETERS
//  XLEN     32               operand/result width, >= 8
//  SHAMT_W  $clog2(XLEN)     shift-amount bits taken from d2[SHAMT_W-1:0]
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands/control valid
//  in_ready   out  1        block can accept (state==IDLE)
//  d1         in   XLEN     operand 1 (rs1)
//  d2         in   XLEN     operand 2 (rs2/imm)
//  control    in   4        opcode, table below
//  flush      in   1        synchronous abort of any op in flight
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  result     out  XLEN     registered result
//  busy       out  1        state!=IDLE
// BEHAVIOUR
//  Opcodes: 0000 ADD, 0001 SLL, 0010 SLT(signed), 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND,
//   1000 SUB, 1001 MUL(low XLEN), 1010 MULHU(high XLEN, unsigned), 1011 DIVU, 1100 REMU,
//   1101 SRA (true arithmetic shift, sign fills from d1[XLEN-1]), 1110 DIV, 1111 REM (signed).
//  All arithmetic mod 2^XLEN; SLT/SLTU produce 1 or 0 zero-extended to XLEN.
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, counter=0, all datapath regs 0.
//  FSM: IDLE --accept & simple op--> DONE; IDLE --accept & mul/div--> BUSY;
//   BUSY --counter==XLEN-1--> DONE; DONE --out_ready--> IDLE.
//  Accept = in_valid & in_ready; operands/control captured on that edge; later input changes ignored.
//  Latency: simple ops out_valid the cycle after accept (1); mul/div after XLEN+1 cycles
//   (1 load + XLEN iterate, result written on final iterate edge, then DONE).
//  Throughput: no accept while DONE; in_ready=0 in BUSY and DONE (no bypass; next accept is
//   the cycle after out_valid&out_ready).
//  DONE: out_valid=1, result stable until out_ready sampled high; out_valid drops next edge.
//  MUL/MULHU: 2*XLEN product register, one multiplier bit per cycle (LSB first).
//  DIV family: restoring, one quotient bit per cycle on |d1|,|d2|; signed fix-up on final edge:
//   quotient negated if signs differ, remainder takes sign of d1.
//  Divide by zero: DIVU/DIV -> all ones; REMU/REM -> d1. Still takes full XLEN+1 cycles.
//  Signed overflow (d1=most-negative, d2=-1): DIV -> d1, REM -> 0.
//  flush=1: next edge state=IDLE, out_valid=0, counter=0, result unchanged; flush beats accept
//   (in_valid ignored while flush=1) and beats out_ready. Flush in IDLE is a no-op.
//  Reset mid-op: immediate abort, reset values above; no partial result ever presented.
//  Undefined control impossible (all 16 codes assigned).
// TESTING
//  ADD 0x7FFFFFFF+1 -> 0x80000000 one cycle after accept; SUB 0-1 -> 0xFFFFFFFF; in_ready low 1 cycle.
//  SRA d1=0x80000000,d2=4 -> 0xF8000000; SRL same -> 0x08000000; SLT 0xFFFFFFFF<1 -> 1, SLTU -> 0.
//  MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, MULHU -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept.
//  DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5;
//   DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid,result stable, in_ready=0;
//   raise out_ready -> out_valid low next cycle, new op accepted following cycle.
//  flush at BUSY cycle 5 of DIVU, and rst_n pulse mid-MUL -> IDLE, out_valid=0, no stale result;
//   next ADD returns correct value. Repeat ADD/MUL with XLEN=16 for parametrisation.

Source files
------------

// File: rtl/alu_iter.sv
// Execute-stage ALU with registered results and iterative multiply/divide.
// Simple ops complete the cycle after accept; MUL/MULHU/DIVU/REMU/DIV/REM
// take one load cycle plus XLEN iterations on a shared shift-add/restoring datapath.
module alu_iter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    input  logic [3:0]      control,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic                 accept;
    logic                 is_iter_in, mul_in, signed_in;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      simple_res;
    logic [XLEN-1:0]      dvd_abs, dvs_abs;
    logic [CNT_W-1:0]     counter;
    logic [3:0]           op;
    logic [XLEN-1:0]      hi, lo, opnd;
    logic                 neg_q, neg_r;
    logic                 op_is_mul;
    logic [XLEN-1:0]      mul_add;
    logic [XLEN:0]        mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]      step_hi, step_lo, final_res;

    // Input-side decode: accept condition, op class and operand magnitudes
    always_comb begin
        accept     = in_valid && (state == IDLE) && !flush;
        mul_in     = (control == OP_MUL) || (control == OP_MULHU);
        signed_in  = (control == OP_DIV) || (control == OP_REM);
        is_iter_in = mul_in || signed_in || (control == OP_DIVU) || (control == OP_REMU);
        dvd_abs    = (signed_in && d1[XLEN-1]) ? -d1 : d1;
        dvs_abs    = (signed_in && d2[XLEN-1]) ? -d2 : d2;
    end

    // Single-cycle results, written on the accept edge
    always_comb begin
        shamt      = d2[SHAMT_W-1:0];
        simple_res = '0;
        case (control)
            OP_ADD:  simple_res = d1 + d2;
            OP_SLL:  simple_res = d1 << shamt;
            OP_SLT:  simple_res = XLEN'($signed(d1) < $signed(d2));
            OP_SLTU: simple_res = XLEN'(d1 < d2);
            OP_XOR:  simple_res = d1 ^ d2;
            OP_SRL:  simple_res = d1 >> shamt;
            OP_OR:   simple_res = d1 | d2;
            OP_AND:  simple_res = d1 & d2;
            OP_SUB:  simple_res = d1 - d2;
            OP_SRA:  simple_res = $unsigned($signed(d1) >>> shamt);
            default: simple_res = '0;
        endcase
    end

    // One iteration: shift-add multiply (LSB first) or restoring divide step
    always_comb begin
        op_is_mul = (op == OP_MUL) || (op == OP_MULHU);
        mul_add   = lo[0] ? opnd : '0;
        mul_sum   = {1'b0, hi} + {1'b0, mul_add};
        div_sh    = {hi, lo[XLEN-1]};
        div_diff  = div_sh - {1'b0, opnd};
        if (op_is_mul) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], 1'b1};
        end else begin
            step_hi = div_sh[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], 1'b0};
        end
        case (op)
            OP_MUL:   final_res = step_lo;
            OP_MULHU: final_res = step_hi;
            OP_DIVU:  final_res = step_lo;
            OP_REMU:  final_res = step_hi;
            OP_DIV:   final_res = neg_q ? -step_lo : step_lo;
            OP_REM:   final_res = neg_r ? -step_hi : step_hi;
            default:  final_res = '0;
        endcase
    end

    // Next-state logic; flush overrides both accept and out_ready
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = is_iter_in ? BUSY : DONE;
                BUSY:    if (counter == CNT_LAST) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            in_ready  <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Operand capture, iteration registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            op      <= OP_ADD;
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            counter <= '0;
        end else if (accept) begin
            op      <= control;
            counter <= '0;
            if (!is_iter_in) begin
                result <= simple_res;
            end else if (mul_in) begin
                hi    <= '0;
                lo    <= d2;
                opnd  <= d1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                hi    <= '0;
                lo    <= dvd_abs;
                opnd  <= dvs_abs;
                // Divide by zero keeps the all-ones quotient unsigned
                neg_q <= signed_in && (d1[XLEN-1] ^ d2[XLEN-1]) && (|d2);
                neg_r <= signed_in && d1[XLEN-1];
            end
        end else if (state == BUSY) begin
            hi <= step_hi;
            lo <= step_lo;
            if (counter == CNT_LAST) begin
                counter <= '0;
                result  <= final_res;
            end else begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: XLEN=32 and XLEN=16 instances, a behavioural reference
// model with a per-cycle compare process, and directed vectors with literal expectations.
module tb_alu_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [2];
    logic        flush [2];
    logic        out_ready [2];
    logic [3:0]  control [2];
    logic [63:0] d1 [2];
    logic [63:0] d2 [2];
    logic        in_ready [2];
    logic        out_valid [2];
    logic        busy [2];
    logic [31:0] res0;
    logic [15:0] res1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: op outstanding, edges left, expected and held result
    bit          pend [2]  = '{1'b0, 1'b0};
    int          remc [2]  = '{0, 0};
    logic [63:0] mexp [2]  = '{64'd0, 64'd0};
    logic [63:0] mhold [2] = '{64'd0, 64'd0};

    always #5 clk = ~clk;

    alu_iter #(.XLEN(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .d1(d1[0][31:0]), .d2(d2[0][31:0]), .control(control[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res0), .busy(busy[0])
    );

    alu_iter #(.XLEN(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .d1(d1[1][15:0]), .d2(d2[1][15:0]), .control(control[1]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res1), .busy(busy[1])
    );

    function automatic int wid(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [63:0] getres(input int k);
        return (k == 0) ? {32'd0, res0} : {48'd0, res1};
    endfunction

    function automatic bit is_iter(input logic [3:0] op);
        return op inside {4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
    endfunction

    // Architectural result of one op at width w, using plain 64-bit arithmetic
    function automatic logic [63:0] ref_op(input int w, input logic [3:0] op,
                                           input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] m, a, b, r, p;
        longint      sa, sb;
        int          sh;
        m  = (64'd1 << w) - 64'd1;
        a  = a_in & m;
        b  = b_in & m;
        sa = a[w-1] ? $signed(a | ~m) : $signed(a);
        sb = b[w-1] ? $signed(b | ~m) : $signed(b);
        sh = int'(b & 64'(w - 1));
        p  = a * b;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a << sh;
            4'h2: r = (sa < sb) ? 64'd1 : 64'd0;
            4'h3: r = (a < b) ? 64'd1 : 64'd0;
            4'h4: r = a ^ b;
            4'h5: r = a >> sh;
            4'h6: r = a | b;
            4'h7: r = a & b;
            4'h8: r = a - b;
            4'h9: r = p;
            4'hA: r = p >> w;
            4'hB: r = (b == 0) ? m : a / b;
            4'hC: r = (b == 0) ? a : a % b;
            4'hD: r = 64'(sa >>> sh);
            4'hE: r = (b == 0) ? m : 64'(sa / sb);
            default: r = (b == 0) ? a : 64'(sa % sb);
        endcase
        return r & m;
    endfunction

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, act, exp);
        end
    endtask

    // Model: advance on each edge, async clear on reset
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend[k]  = 1'b0;
                remc[k]  = 0;
                mhold[k] = 64'd0;
            end else if (flush[k]) begin
                pend[k] = 1'b0;
            end else if (pend[k]) begin
                if (remc[k] == 0) begin
                    if (out_ready[k]) pend[k] = 1'b0;
                end else begin
                    remc[k] = remc[k] - 1;
                    if (remc[k] == 0) mhold[k] = mexp[k];
                end
            end else if (in_valid[k]) begin
                pend[k] = 1'b1;
                mexp[k] = ref_op(wid(k), control[k], d1[k], d2[k]);
                remc[k] = is_iter(control[k]) ? wid(k) : 0;
                if (remc[k] == 0) mhold[k] = mexp[k];
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("out_valid", k, 64'(out_valid[k]), 64'(pend[k] && remc[k] == 0));
            check("in_ready",  k, 64'(in_ready[k]),  64'(!pend[k]));
            check("busy",      k, 64'(busy[k]),      64'(pend[k]));
            check("result",    k, getres(k),         mhold[k]);
        end
    end

    // Issue one op, check latency/result, hold backpressure bp cycles, then drain
    task automatic run_op(input int k, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] want,
                          input int want_lat, input int bp);
        int n;
        n = 0;
        while (!in_ready[k] && n < 100) begin @(posedge clk); #1; n++; end
        check("ready_wait", k, 64'(in_ready[k]), 64'd1);
        control[k] = op; d1[k] = a; d2[k] = b; in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0; d1[k] = ~a; d2[k] = ~b; control[k] = op ^ 4'h5;
        n = 1;
        while (!out_valid[k] && n < 100) begin @(posedge clk); #1; n++; end
        check("latency", k, 64'(n), 64'(want_lat));
        check("dir_result", k, getres(k), want);
        repeat (bp) begin
            @(posedge clk); #1;
            check("bp_valid", k, 64'(out_valid[k]), 64'd1);
            check("bp_ready", k, 64'(in_ready[k]), 64'd0);
            check("bp_result", k, getres(k), want);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check("valid_drop", k, 64'(out_valid[k]), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b0;
            control[k] = 4'h0; d1[k] = 64'd0; d2[k] = 64'd0;
        end
        // Pin the model itself against hand-computed values
        check("pin_sra",   0, ref_op(32, 4'hD, 64'h80000000, 64'd4), 64'hF8000000);
        check("pin_div",   0, ref_op(32, 4'hE, 64'hFFFFFFF9, 64'd2), 64'hFFFFFFFD);
        check("pin_remov", 0, ref_op(32, 4'hF, 64'h80000000, 64'hFFFFFFFF), 64'd0);
        check("pin_mulhu", 1, ref_op(16, 4'hA, 64'hFFFF, 64'hFFFF), 64'hFFFE);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_result", 0, getres(0), 64'd0);
        check("rst_ready", 0, 64'(in_ready[0]), 64'd1);

        run_op(0, 4'h0, 64'h7FFFFFFF, 64'd1, 64'h80000000, 1, 0);
        run_op(0, 4'h8, 64'd0, 64'd1, 64'hFFFFFFFF, 1, 0);
        run_op(0, 4'hD, 64'h80000000, 64'd4, 64'hF8000000, 1, 0);
        run_op(0, 4'h5, 64'h80000000, 64'd4, 64'h08000000, 1, 0);
        run_op(0, 4'h2, 64'hFFFFFFFF, 64'd1, 64'd1, 1, 0);
        run_op(0, 4'h3, 64'hFFFFFFFF, 64'd1, 64'd0, 1, 0);
        run_op(0, 4'h1, 64'd1, 64'h3F, 64'h80000000, 1, 0);
        run_op(0, 4'h4, 64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0, 1, 0);
        run_op(0, 4'h6, 64'hF0F0F0F0, 64'hFF00FF00, 64'hFFF0FFF0, 1, 0);
        run_op(0, 4'h7, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 1, 0);
        run_op(0, 4'hD, 64'h7FFFFFF0, 64'h24, 64'h07FFFFFF, 1, 0);
        run_op(0, 4'h9, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1, 33, 0);
        run_op(0, 4'hA, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, 0);
        run_op(0, 4'h9, 64'd7, 64'd6, 64'h2A, 33, 0);
        run_op(0, 4'hA, 64'h10000, 64'h10000, 64'h1, 33, 0);
        run_op(0, 4'hE, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33, 0);
        run_op(0, 4'hF, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33, 0);
        run_op(0, 4'hB, 64'd5, 64'd0, 64'hFFFFFFFF, 33, 0);
        run_op(0, 4'hC, 64'd5, 64'd0, 64'd5, 33, 0);
        run_op(0, 4'hE, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33, 0);
        run_op(0, 4'hF, 64'h80000000, 64'hFFFFFFFF, 64'd0, 33, 0);
        run_op(0, 4'hB, 64'd100, 64'd7, 64'd14, 33, 0);
        run_op(0, 4'hC, 64'd100, 64'd7, 64'd2, 33, 0);
        run_op(0, 4'hE, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFF, 33, 0);
        run_op(0, 4'hF, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFB, 33, 0);
        run_op(0, 4'hF, 64'd7, 64'hFFFFFFFE, 64'd1, 33, 0);
        run_op(0, 4'hE, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFFD, 33, 0);
        run_op(0, 4'h0, 64'd3, 64'd4, 64'd7, 1, 10);

        // Flush during BUSY cycle 5 of a DIVU
        control[0] = 4'hB; d1[0] = 64'd100; d2[0] = 64'd7; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        check("flush_valid", 0, 64'(out_valid[0]), 64'd0);
        check("flush_ready", 0, 64'(in_ready[0]), 64'd1);
        check("flush_result", 0, getres(0), 64'd7);
        repeat (40) begin @(posedge clk); #1; end

        // Flush beats accept in IDLE
        control[0] = 4'h0; d1[0] = 64'd1; d2[0] = 64'd1; in_valid[0] = 1'b1; flush[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; flush[0] = 1'b0;
        check("flush_acc_busy", 0, 64'(busy[0]), 64'd0);
        check("flush_acc_result", 0, getres(0), 64'd7);
        run_op(0, 4'h0, 64'd1, 64'd2, 64'd3, 1, 0);

        // Reset pulse in the middle of a MUL
        control[0] = 4'h9; d1[0] = 64'd7; d2[0] = 64'd6; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        check("rst_mid_valid", 0, 64'(out_valid[0]), 64'd0);
        check("rst_mid_busy", 0, 64'(busy[0]), 64'd0);
        check("rst_mid_result", 0, getres(0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        run_op(0, 4'h0, 64'd10, 64'd20, 64'h1E, 1, 0);

        // Narrow instance
        run_op(1, 4'h0, 64'h7FFF, 64'd1, 64'h8000, 1, 0);
        run_op(1, 4'h9, 64'hFFFF, 64'hFFFF, 64'h1, 17, 0);
        run_op(1, 4'hA, 64'hFFFF, 64'hFFFF, 64'hFFFE, 17, 3);
        run_op(1, 4'hE, 64'hFFF9, 64'd2, 64'hFFFD, 17, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
